// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline control block:
// FSM state encoding, timeout width and the strobe bundle.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_BUS_WAIT  = 2'd1,
    ST_JUMP_PEND = 2'd2
  } state_e;

  localparam int TMO_W = 16;

  typedef struct packed {
    logic        jump_en;
    logic [31:0] jump_addr;
    logic [2:0]  hold;
    logic [1:0]  flush;
  } ctrl_t;

endpackage

// File: rtl/pipe_ctrl_tmo.sv
// Bus-hold timeout: counts held cycles, fires a
// single registered pulse, then saturates.
module pipe_ctrl_tmo
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic bus_hold_i,
  output logic bus_timeout_o
);

  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_PRE = TMO_W'(TIMEOUT - 1);

  logic [TMO_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt           <= '0;
      bus_timeout_o <= 1'b0;
    end else if (!bus_hold_i) begin
      cnt           <= '0;
      bus_timeout_o <= 1'b0;
    end else begin
      // pulse lands the cycle after cnt reaches TIMEOUT
      bus_timeout_o <= (cnt == TMO_PRE);
      if (cnt != TMO_MAX)
        cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: merges jump, ex hold and bus hold
// into per-stage hold/flush strobes and PC redirect.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_flag_ex_i,
  input  logic        bus_hold_i,
  output logic        jump_en_o,
  output logic [31:0] jump_addr_o,
  output logic        hold_pc_o,
  output logic        hold_if_id_o,
  output logic        hold_id_ex_o,
  output logic        flush_if_id_o,
  output logic        flush_id_ex_o,
  output logic        bus_timeout_o,
  output logic [31:0] stall_cnt_o
);

  state_e      state, nxt;
  logic [31:0] pend_addr, pend_nxt;
  ctrl_t       c;

  always_comb begin
    c        = '0;
    nxt      = state;
    pend_nxt = pend_addr;
    if (state == ST_JUMP_PEND) begin
      if (bus_hold_i) begin
        c.hold = '1;
      end else begin
        c.jump_en   = 1'b1;
        c.jump_addr = pend_addr;
        c.flush     = '1;
        nxt         = ST_RUN;
      end
    end else if (bus_hold_i) begin
      c.hold = '1;
      if (jump_en_i) begin
        pend_nxt = jump_addr_i;
        nxt      = ST_JUMP_PEND;
      end else begin
        nxt = ST_BUS_WAIT;
      end
    end else if (jump_en_i) begin
      // jump wins over a concurrent ex hold
      c.jump_en   = 1'b1;
      c.jump_addr = jump_addr_i;
      c.flush     = '1;
      nxt         = ST_RUN;
    end else if (hold_flag_ex_i) begin
      c.hold = '1;
      nxt    = ST_RUN;
    end else begin
      nxt = ST_RUN;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_RUN;
      pend_addr <= '0;
    end else begin
      state     <= nxt;
      pend_addr <= pend_nxt;
    end
  end

  assign jump_en_o     = rst & c.jump_en;
  assign jump_addr_o   = rst ? c.jump_addr : '0;
  assign hold_pc_o     = rst & c.hold[2];
  assign hold_if_id_o  = rst & c.hold[1];
  assign hold_id_ex_o  = rst & c.hold[0];
  assign flush_if_id_o = rst & c.flush[1];
  assign flush_id_ex_o = rst & c.flush[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_cnt_o <= '0;
    else if (hold_pc_o)
      stall_cnt_o <= stall_cnt_o + 1'b1;
  end

  pipe_ctrl_tmo #(
    .TIMEOUT(TIMEOUT)
  ) u_tmo (
    .clk          (clk),
    .rst          (rst),
    .bus_hold_i   (bus_hold_i),
    .bus_timeout_o(bus_timeout_o)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed vectors push
// expected strobes, a negedge monitor pops and compares.
module tb_pipe_ctrl;

  typedef struct packed {
    logic        je;
    logic [31:0] ja;
    logic [2:0]  hold;
    logic [1:0]  flush;
    logic        tmo;
    logic [31:0] stall;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        jump_en_i = 1'b1;
  logic [31:0] jump_addr_i = 32'h55;
  logic        hold_flag_ex_i = 1'b0;
  logic        bus_hold_i = 1'b1;
  logic        jump_en_o;
  logic [31:0] jump_addr_o;
  logic        hold_pc_o;
  logic        hold_if_id_o;
  logic        hold_id_ex_o;
  logic        flush_if_id_o;
  logic        flush_id_ex_o;
  logic        bus_timeout_o;
  logic [31:0] stall_cnt_o;

  exp_t  exp_q[$];
  string name_q[$];
  int    tests = 0;
  int    fails = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(
    .TIMEOUT(4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .jump_en_i     (jump_en_i),
    .jump_addr_i   (jump_addr_i),
    .hold_flag_ex_i(hold_flag_ex_i),
    .bus_hold_i    (bus_hold_i),
    .jump_en_o     (jump_en_o),
    .jump_addr_o   (jump_addr_o),
    .hold_pc_o     (hold_pc_o),
    .hold_if_id_o  (hold_if_id_o),
    .hold_id_ex_o  (hold_id_ex_o),
    .flush_if_id_o (flush_if_id_o),
    .flush_id_ex_o (flush_id_ex_o),
    .bus_timeout_o (bus_timeout_o),
    .stall_cnt_o   (stall_cnt_o)
  );

  function automatic exp_t ev(logic je, logic [31:0] ja,
                              logic h, logic f, logic t,
                              logic [31:0] st);
    exp_t x;
    x.je    = je;
    x.ja    = ja;
    x.hold  = {3{h}};
    x.flush = {2{f}};
    x.tmo   = t;
    x.stall = st;
    return x;
  endfunction

  task automatic cyc(input string nm, input logic r,
                     input logic je, input logic [31:0] ja,
                     input logic hx, input logic bh,
                     input exp_t ex);
    @(posedge clk);
    #1;
    rst            = r;
    jump_en_i      = je;
    jump_addr_i    = ja;
    hold_flag_ex_i = hx;
    bus_hold_i     = bh;
    exp_q.push_back(ex);
    name_q.push_back(nm);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  x;
      exp_t  g;
      string n;
      x = exp_q.pop_front();
      n = name_q.pop_front();
      g.je    = jump_en_o;
      g.ja    = jump_addr_o;
      g.hold  = {hold_pc_o, hold_if_id_o, hold_id_ex_o};
      g.flush = {flush_if_id_o, flush_id_ex_o};
      g.tmo   = bus_timeout_o;
      g.stall = stall_cnt_o;
      tests++;
      if (g !== x) begin
        fails++;
        $display("FAIL %s: got je=%b ja=%h hold=%b flush=%b tmo=%b stall=%h ; want je=%b ja=%h hold=%b flush=%b tmo=%b stall=%h",
                 n, g.je, g.ja, g.hold, g.flush, g.tmo, g.stall,
                 x.je, x.ja, x.hold, x.flush, x.tmo, x.stall);
      end
    end
  end

  initial begin
    // reset held with traffic on the inputs
    cyc("rst_a", 0, 1, 32'h55, 0, 1, ev(0, 0, 0, 0, 0, 0));
    cyc("rst_b", 0, 1, 32'h66, 1, 1, ev(0, 0, 0, 0, 0, 0));
    cyc("rst_rel", 1, 0, 0, 0, 0, ev(0, 0, 0, 0, 0, 0));

    // jump beats ex hold
    cyc("jmp_hx", 1, 1, 32'h100, 1, 0,
        ev(1, 32'h100, 0, 1, 0, 0));

    // ex hold for three cycles
    cyc("hx1", 1, 0, 0, 1, 0, ev(0, 0, 1, 0, 0, 0));
    cyc("hx2", 1, 0, 0, 1, 0, ev(0, 0, 1, 0, 0, 1));
    cyc("hx3", 1, 0, 0, 1, 0, ev(0, 0, 1, 0, 0, 2));
    cyc("hx_end", 1, 0, 0, 0, 0, ev(0, 0, 0, 0, 0, 3));

    // bus hold with two jumps, first one is replayed
    cyc("bh1", 1, 0, 0, 0, 1, ev(0, 0, 1, 0, 0, 3));
    cyc("bh2_j200", 1, 1, 32'h200, 0, 1,
        ev(0, 0, 1, 0, 0, 4));
    cyc("bh3_j300", 1, 1, 32'h300, 0, 1,
        ev(0, 0, 1, 0, 0, 5));
    cyc("bh4", 1, 0, 0, 0, 1, ev(0, 0, 1, 0, 0, 6));
    cyc("replay", 1, 1, 32'h300, 1, 0,
        ev(1, 32'h200, 0, 1, 1, 7));
    cyc("post_replay", 1, 0, 0, 0, 0,
        ev(0, 0, 0, 0, 0, 7));

    // ten-cycle bus hold, one timeout pulse
    for (int k = 1; k <= 10; k++)
      cyc($sformatf("tmo_w1_%0d", k), 1, 0, 0, 0, 1,
          ev(0, 0, 1, 0, (k == 5), 32'(6 + k)));
    cyc("tmo_gap", 1, 0, 0, 0, 0, ev(0, 0, 0, 0, 0, 17));

    // six-cycle window, second pulse
    for (int k = 1; k <= 6; k++)
      cyc($sformatf("tmo_w2_%0d", k), 1, 0, 0, 0, 1,
          ev(0, 0, 1, 0, (k == 5), 32'(16 + k)));
    // release straight into an ex hold
    cyc("bw_rel_hx", 1, 0, 0, 1, 0, ev(0, 0, 1, 0, 0, 23));
    cyc("idle", 1, 0, 0, 0, 0, ev(0, 0, 0, 0, 0, 24));

    // stall counter wrap
    @(posedge clk);
    #1;
    hold_flag_ex_i = 1'b1;
    force dut.stall_cnt_o = 32'hFFFF_FFFF;
    exp_q.push_back(ev(0, 0, 1, 0, 0, 32'hFFFF_FFFF));
    name_q.push_back("wrap_pre");
    #5;
    release dut.stall_cnt_o;
    cyc("wrap_post", 1, 0, 0, 0, 0, ev(0, 0, 0, 0, 0, 0));

    // reset while a jump is pending
    cyc("pend_set", 1, 1, 32'h400, 0, 1,
        ev(0, 0, 1, 0, 0, 0));
    cyc("pend_rst", 0, 1, 32'h400, 0, 1,
        ev(0, 0, 0, 0, 0, 0));
    cyc("pend_drop", 1, 0, 0, 0, 0, ev(0, 0, 0, 0, 0, 0));
    cyc("pend_idle", 1, 0, 0, 0, 0, ev(0, 0, 0, 0, 0, 0));

    for (int i = 0; i < 5 && exp_q.size() > 0; i++)
      @(negedge clk);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, want 0",
               exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control block for the 3-stage core (pc_reg → if_id → id_ex → ex). It merges the execute stage's jump request (jump_en/jump_addr), the execute hold request and the data-bus hold into one set of per-stage hold and flush strobes, plus the PC redirect. A jump raised while the bus holds the pipeline is latched and replayed when the bus releases. It also provides a bus-hold timeout pulse and a stall-cycle performance counter.

## Interface
- TIMEOUT, 255: consecutive bus-hold cycles before bus_timeout_o fires (1..65535)
- clk  in  1  core clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- jump_en_i  in  1  jump/branch taken, from ex (combinational)
- jump_addr_i  in  32  jump target, from ex
- hold_flag_ex_i  in  1  ex multi-cycle hold request (level)
- bus_hold_i  in  1  data-bus busy hold request (level)
- jump_en_o  out  1  PC redirect to pc_reg
- jump_addr_o  out  32  redirect target
- hold_pc_o, hold_if_id_o, hold_id_ex_o  out  1 each  stage hold (keep contents)
- flush_if_id_o, flush_id_ex_o  out  1 each  stage flush (load NOP next edge)
- bus_timeout_o  out  1  one-cycle registered timeout pulse
- stall_cnt_o  out  32  cycles with hold_pc_o=1, wraps

## Operation
- States: RUN, BUS_WAIT, JUMP_PEND. The state register and pend_addr (32 bits) are the only control state.
- Outputs are combinational from state and inputs. While rst=0 all outputs are 0.
- RUN, bus_hold_i=1, jump_en_i=0:
  - all three holds = 1.
  - next state BUS_WAIT.
- RUN, bus_hold_i=1, jump_en_i=1:
  - all holds = 1, jump_en_o = 0.
  - pend_addr ← jump_addr_i; next state JUMP_PEND.
- RUN, bus_hold_i=0, jump_en_i=1:
  - jump_en_o = 1, jump_addr_o = jump_addr_i.
  - both flushes = 1, all holds = 0. A simultaneous hold_flag_ex_i is ignored because the jump wins.
- RUN, bus_hold_i=0, jump_en_i=0, hold_flag_ex_i=1: all holds = 1, no flush.
- RUN, all requests idle: all strobes 0.
- BUS_WAIT:
  - bus_hold_i=1: all holds = 1. If jump_en_i=1, pend_addr ← jump_addr_i and go to JUMP_PEND.
  - bus_hold_i=0: outputs and next state follow the RUN rules in the same cycle (zero-bubble release).
- JUMP_PEND:
  - bus_hold_i=1: all holds = 1. jump_en_i is ignored; the first latched jump stays authoritative.
  - bus_hold_i=0: jump_en_o = 1, jump_addr_o = pend_addr, both flushes = 1, no holds; next state RUN. hold_flag_ex_i and jump_en_i are ignored that cycle.
- jump_addr_o = 0 whenever jump_en_o = 0.
- Hold and flush are never both 1 on the same stage.
- Timeout counter (16 bits):
  - increments each cycle bus_hold_i=1 and clears when bus_hold_i=0.
  - when the count reaches TIMEOUT, bus_timeout_o = 1 on the next cycle for exactly one cycle.
  - the counter then saturates with no further pulse until bus_hold_i drops.
  - no forced release of the pipeline.
- stall_cnt_o increments at each edge where hold_pc_o=1 and wraps 0xFFFF_FFFF → 0.

## Timing
- Reset (async assert, sync use after deassert): state=RUN, pend_addr=0, timeout count=0, bus_timeout_o=0, stall_cnt_o=0.
- Hold, flush and jump strobes: 0-cycle latency from inputs.
- Replayed jump: issued in the first cycle bus_hold_i=0 after JUMP_PEND; pc_reg loads it at that edge.
- Reset mid-JUMP_PEND: the pending jump is discarded; return to RUN.
- bus_timeout_o: registered, 1 cycle after count==TIMEOUT.

## Structure
- State encodings (RUN/BUS_WAIT/JUMP_PEND) and TIMEOUT counter width go in defines.v next to the opcode defines.
- One sub-module is natural: pipe_ctrl_tmo (timeout counter + pulse). Everything else stays in pipe_ctrl.

## Test plan
- Reset mid-traffic, with jump_en_i=1 and bus_hold_i=1 driven at the reset edge → all outputs 0 while rst=0; stall_cnt_o=0 after release.
- RUN, jump_en_i=1, jump_addr_i=0x0000_0100, hold_flag_ex_i=1 → same cycle jump_en_o=1, addr 0x100, both flushes 1, holds 0.
- hold_flag_ex_i high for 3 cycles → 3 cycles of all holds, no flush; stall_cnt_o advances 0→3.
- bus_hold_i high for 4 cycles with jump_en_i=1 to 0x200 in cycle 2 and to 0x300 in cycle 3 → holds for 4 cycles, then a 1-cycle jump_en_o to 0x200 with flushes; 0x300 never issued.
- TIMEOUT=4, bus_hold_i high for 10 cycles → bus_timeout_o high exactly once, the cycle after the 4th hold cycle; a second 6-cycle hold window produces a second pulse.
- stall_cnt_o preloaded via force to 0xFFFF_FFFF, one held cycle → wraps to 0.
